// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the 5-stage pipeline sequencer: stall/flush vectors,
// sequencer states and the register bus width.
package pipe_ctrl_pkg;

    localparam int REG_BUS_WIDTH = 32;
    typedef logic [REG_BUS_WIDTH-1:0] reg_bus_t;

    // Stall vector bit order: pc, if/id, id/ex, ex/mem, mem/wb, wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [5:0] FLUSH_NONE = 6'b000000;
    localparam logic [5:0] FLUSH_TRAP = 6'b011110;

    typedef enum logic [1:0] {
        PCTRL_RUN   = 2'd0,
        PCTRL_DRAIN = 2'd1,
        PCTRL_REDIR = 2'd2,
        PCTRL_HALT  = 2'd3
    } pctrl_state_t;

    // Deepest requesting stage dominates: mem > ex > id
    function automatic logic [5:0] run_stall(input logic id, input logic ex, input logic mem);
        if (mem)
            return STALL_MEM;
        else if (ex)
            return STALL_EX;
        else if (id)
            return STALL_ID;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles plus a
// sticky timeout flag that only reset clears.
module stall_wdog #(
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic timeout
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_CYCLES);

    logic [WDOG_W-1:0] cnt;
    logic [WDOG_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (clr)
            cnt_next = '0;
        else if (!hold && inc && (cnt != LIMIT))
            cnt_next = cnt + WDOG_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            timeout <= timeout | (cnt_next == LIMIT);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector, jump/trap redirect arbitration, trap
// drain sequencing, debug halt and stall watchdog. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        jump_req_i,
    input  reg_bus_t    jump_pc_i,
    input  logic        trap_req_i,
    input  reg_bus_t    trap_vec_i,
    input  logic        halt_req_i,
    output logic [5:0]  stall_o,
    output logic [5:0]  flush_o,
    output logic        redirect_req_o,
    output reg_bus_t    redirect_pc_o,
    output logic        trap_busy_o,
    output logic        halted_o,
    output logic        stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    pctrl_state_t state;
    pctrl_state_t state_next;
    reg_bus_t     trap_pc_r;
    logic         trap_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= PCTRL_RUN;
            trap_pc_r <= '0;
        end else begin
            state <= state_next;
            if (trap_load)
                trap_pc_r <= trap_vec_i;
        end
    end

    always_comb begin
        state_next     = state;
        trap_load      = 1'b0;
        stall_o        = STALL_NONE;
        flush_o        = FLUSH_NONE;
        redirect_req_o = 1'b0;
        redirect_pc_o  = '0;
        trap_busy_o    = 1'b0;
        halted_o       = 1'b0;
        case (state)
            PCTRL_RUN: begin
                stall_o = run_stall(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
                // A suppressed jump is simply re-asserted by idu later
                if (jump_req_i && !trap_req_i && (stall_o == STALL_NONE)) begin
                    redirect_req_o = 1'b1;
                    redirect_pc_o  = jump_pc_i;
                end
                if (trap_req_i) begin
                    trap_load  = 1'b1;
                    state_next = stallreq_mem_i ? PCTRL_DRAIN : PCTRL_REDIR;
                end else if (halt_req_i) begin
                    state_next = PCTRL_HALT;
                end
            end
            PCTRL_DRAIN: begin
                stall_o     = STALL_MEM;
                trap_busy_o = 1'b1;
                if (!stallreq_mem_i)
                    state_next = PCTRL_REDIR;
            end
            PCTRL_REDIR: begin
                redirect_req_o = 1'b1;
                redirect_pc_o  = trap_pc_r;
                flush_o        = FLUSH_TRAP;
                trap_busy_o    = 1'b1;
                state_next     = PCTRL_RUN;
            end
            PCTRL_HALT: begin
                stall_o  = STALL_ALL;
                halted_o = 1'b1;
                // A trap raised while halted is taken before resuming
                if (!halt_req_i) begin
                    if (trap_req_i) begin
                        trap_load  = 1'b1;
                        state_next = stallreq_mem_i ? PCTRL_DRAIN : PCTRL_REDIR;
                    end else begin
                        state_next = PCTRL_RUN;
                    end
                end
            end
            default: state_next = PCTRL_RUN;
        endcase
    end

    logic wdog_inc;
    logic wdog_clr;
    logic wdog_hold;

    assign wdog_clr  = (stall_o == STALL_NONE);
    assign wdog_hold = (state == PCTRL_HALT);
    assign wdog_inc  = !wdog_clr && ((state == PCTRL_RUN) || (state == PCTRL_DRAIN));

    stall_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES),
        .WDOG_W      (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (wdog_inc),
        .clr     (wdog_clr),
        .hold    (wdog_hold),
        .timeout (stall_timeout_o)
    );

`ifdef PIPE_CTRL_PERF_EN
    // Forwarded jumps and REDIR cycles both show up as redirect_req_o
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cyc_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (stall_o[0])
                perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
            if (redirect_req_o)
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int WD = 4;

    logic        clk;
    logic        rst_n;
    logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        jump_req_i;
    logic [31:0] jump_pc_i;
    logic        trap_req_i;
    logic [31:0] trap_vec_i;
    logic        halt_req_i;
    logic [5:0]  stall_o, flush_o;
    logic        redirect_req_o;
    logic [31:0] redirect_pc_o;
    logic        trap_busy_o, halted_o, stall_timeout_o;

    pipe_ctrl #(.WDOG_CYCLES(WD), .WDOG_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .stallreq_mem_i  (stallreq_mem_i),
        .jump_req_i      (jump_req_i),
        .jump_pc_i       (jump_pc_i),
        .trap_req_i      (trap_req_i),
        .trap_vec_i      (trap_vec_i),
        .halt_req_i      (halt_req_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_req_o  (redirect_req_o),
        .redirect_pc_o   (redirect_pc_o),
        .trap_busy_o     (trap_busy_o),
        .halted_o        (halted_o),
        .stall_timeout_o (stall_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what the core is doing, as plain flags and counters
    bit          m_halted, m_draining, m_redirecting, m_timeout;
    logic [31:0] m_trap_pc;
    int          m_stalled_run;

    logic [5:0]  e_stall, e_flush;
    logic        e_redir, e_busy, e_halted;
    logic [31:0] e_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic calc_expect();
        e_stall = 6'b0; e_flush = 6'b0; e_redir = 1'b0; e_pc = 32'h0; e_busy = 1'b0; e_halted = 1'b0;
        if (m_redirecting) begin
            e_flush = 6'b011110; e_redir = 1'b1; e_pc = m_trap_pc; e_busy = 1'b1;
        end else if (m_draining) begin
            e_stall = 6'b011111; e_busy = 1'b1;
        end else if (m_halted) begin
            e_stall = 6'b111111; e_halted = 1'b1;
        end else begin
            if (stallreq_mem_i)     e_stall = 6'b011111;
            else if (stallreq_ex_i) e_stall = 6'b001111;
            else if (stallreq_id_i) e_stall = 6'b000111;
            if (jump_req_i && !trap_req_i && e_stall == 6'b0) begin
                e_redir = 1'b1; e_pc = jump_pc_i;
            end
        end
    endtask

    task automatic update_model();
        if (!rst_n) begin
            m_halted = 0; m_draining = 0; m_redirecting = 0; m_timeout = 0;
            m_trap_pc = 32'h0; m_stalled_run = 0;
            return;
        end
        if (e_stall == 6'b0)
            m_stalled_run = 0;
        else if (!(m_halted && !m_draining && !m_redirecting) && m_stalled_run < WD)
            m_stalled_run++;
        if (m_stalled_run >= WD)
            m_timeout = 1;
        if (m_redirecting) begin
            m_redirecting = 0;
        end else if (m_draining) begin
            if (!stallreq_mem_i) begin m_draining = 0; m_redirecting = 1; end
        end else if (m_halted && halt_req_i) begin
            m_halted = 1;
        end else if (trap_req_i) begin
            m_halted = 0; m_trap_pc = trap_vec_i;
            if (stallreq_mem_i) m_draining = 1; else m_redirecting = 1;
        end else if (m_halted) begin
            m_halted = 0;
        end else if (halt_req_i) begin
            m_halted = 1;
        end
    endtask

    task automatic check_model();
        calc_expect();
        chk("stall", {26'b0, stall_o}, {26'b0, e_stall});
        chk("flush", {26'b0, flush_o}, {26'b0, e_flush});
        chk("redirect_req", {31'b0, redirect_req_o}, {31'b0, e_redir});
        chk("redirect_pc", redirect_pc_o, e_pc);
        chk("trap_busy", {31'b0, trap_busy_o}, {31'b0, e_busy});
        chk("halted", {31'b0, halted_o}, {31'b0, e_halted});
        chk("stall_timeout", {31'b0, stall_timeout_o}, {31'b0, m_timeout});
    endtask

    task automatic drive(input bit r, input bit id, input bit ex, input bit mem, input bit jmp,
                         input logic [31:0] jpc, input bit trp, input logic [31:0] tv, input bit hlt);
        rst_n = r; stallreq_id_i = id; stallreq_ex_i = ex; stallreq_mem_i = mem;
        jump_req_i = jmp; jump_pc_i = jpc; trap_req_i = trp; trap_vec_i = tv; halt_req_i = hlt;
        #1;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
        jump_req_i = 0; jump_pc_i = 0; trap_req_i = 0; trap_vec_i = 0; halt_req_i = 0;
        @(posedge clk);
        update_model();
        @(negedge clk);

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_stall", {26'b0, stall_o}, 32'h0);
        chk("rst_flush", {26'b0, flush_o}, 32'h0);
        chk("rst_redirect", {31'b0, redirect_req_o}, 32'h0);
        chk("rst_pc", redirect_pc_o, 32'h0);
        chk("rst_busy", {31'b0, trap_busy_o}, 32'h0);
        chk("rst_halted", {31'b0, halted_o}, 32'h0);
        chk("rst_timeout", {31'b0, stall_timeout_o}, 32'h0);
        advance();

        // Watchdog: four consecutive ex stalls
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
            chk("wdog_not_yet", {31'b0, stall_timeout_o}, 32'h0);
            advance();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wdog_set", {31'b0, stall_timeout_o}, 32'h1);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wdog_sticky", {31'b0, stall_timeout_o}, 32'h1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wdog_rst_clear", {31'b0, stall_timeout_o}, 32'h0);
        advance();

        // Stall priority, jumps suppressed under stall
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("prio_id", {26'b0, stall_o}, 32'h07);
        advance();
        drive(1, 1, 0, 1, 1, 32'h44, 0, 0, 0);
        chk("prio_mem", {26'b0, stall_o}, 32'h1f);
        chk("jump_suppr_mem", {31'b0, redirect_req_o}, 32'h0);
        advance();
        drive(1, 0, 1, 0, 1, 32'h48, 0, 0, 0);
        chk("prio_ex", {26'b0, stall_o}, 32'h0f);
        chk("jump_suppr_ex", {31'b0, redirect_req_o}, 32'h0);
        advance();

        // Clean jump
        drive(1, 0, 0, 0, 1, 32'h80, 0, 0, 0);
        chk("jump_req", {31'b0, redirect_req_o}, 32'h1);
        chk("jump_pc", redirect_pc_o, 32'h80);
        chk("jump_flush", {26'b0, flush_o}, 32'h0);
        advance();

        // Trap with memory wait: three DRAIN cycles then one REDIR
        drive(1, 0, 0, 1, 0, 0, 1, 32'h100, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, (i < 2), 0, 0, 1, 32'h100, 0);
            chk("drain_stall", {26'b0, stall_o}, 32'h1f);
            chk("drain_busy", {31'b0, trap_busy_o}, 32'h1);
            advance();
        end
        drive(1, 0, 0, 0, 0, 0, 1, 32'h100, 0);
        chk("trap_redir_req", {31'b0, redirect_req_o}, 32'h1);
        chk("trap_redir_pc", redirect_pc_o, 32'h100);
        chk("trap_flush", {26'b0, flush_o}, 32'h1e);
        chk("trap_redir_stall", {26'b0, stall_o}, 32'h0);
        chk("trap_redir_busy", {31'b0, trap_busy_o}, 32'h1);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("trap_done_busy", {31'b0, trap_busy_o}, 32'h0);
        advance();

        // Trap and jump in the same cycle
        drive(1, 0, 0, 0, 1, 32'h40, 1, 32'h200, 0);
        chk("tvj_no_jump", {31'b0, redirect_req_o}, 32'h0);
        advance();
        drive(1, 0, 0, 0, 1, 32'h40, 1, 32'h200, 0);
        chk("tvj_redir", {31'b0, redirect_req_o}, 32'h1);
        chk("tvj_pc", redirect_pc_o, 32'h200);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();

        // Halt, then a trap raised during halt taken on release
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
            if (i > 0) begin
                chk("halt_flag", {31'b0, halted_o}, 32'h1);
                chk("halt_stall", {26'b0, stall_o}, 32'h3f);
            end
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 32'h300, 1);
            chk("halt_trap_hold", {31'b0, halted_o}, 32'h1);
            advance();
        end
        drive(1, 0, 0, 0, 0, 0, 1, 32'h300, 0);
        chk("halt_release", {31'b0, halted_o}, 32'h1);
        advance();
        drive(1, 0, 0, 0, 0, 0, 1, 32'h300, 0);
        chk("halt_trap_redir", {31'b0, redirect_req_o}, 32'h1);
        chk("halt_trap_pc", redirect_pc_o, 32'h300);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();

        // Reset while draining abandons the trap
        drive(1, 0, 0, 1, 0, 0, 1, 32'h500, 0);
        advance();
        drive(1, 0, 0, 1, 0, 0, 1, 32'h500, 0);
        chk("rd_busy", {31'b0, trap_busy_o}, 32'h1);
        advance();
        drive(0, 0, 0, 1, 0, 0, 1, 32'h500, 0);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_stall", {26'b0, stall_o}, 32'h0);
        chk("rd_redirect", {31'b0, redirect_req_o}, 32'h0);
        chk("rd_busy_clr", {31'b0, trap_busy_o}, 32'h0);
        chk("rd_flush", {26'b0, flush_o}, 32'h0);
        advance();

        // Randomized traffic against the model
        begin
            bit hl;
            hl = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 9) == 0) hl = ~hl;
                drive(($urandom_range(0, 199) != 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                      $urandom, ($urandom_range(0, 9) == 0), $urandom, hl);
                advance();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Turns per-stage stall requests into the 6-bit stall vector consumed by ifu and the pipeline registers, and arbitrates PC redirects between idu jumps and trap entry, driving the ifu jump port.
Also sequences trap entry: drain the outstanding memory access, then flush and redirect. Provides a debug halt and a stall watchdog.

Parameters:
WDOG_CYCLES, 1024, consecutive stalled cycles before stall_timeout_o is set; legal range 2..65535.
WDOG_W, 16, watchdog counter width; must satisfy 2^WDOG_W > WDOG_CYCLES.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
stallreq_id_i  in  1  idu load-use hazard
stallreq_ex_i  in  1  exu multicycle op busy
stallreq_mem_i  in  1  lsu bus wait
jump_req_i  in  1  idu branch/jump taken
jump_pc_i  in  REG_BUS_WIDTH  idu jump target
trap_req_i  in  1  exception/interrupt request, held by source until trap_busy_o=0
trap_vec_i  in  REG_BUS_WIDTH  trap handler address
halt_req_i  in  1  debug halt level request
stall_o  out  6  bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb
flush_o  out  6  same bit mapping; 1 = load bubble into that register
redirect_req_o  out  1  to ifu jump_req_i
redirect_pc_o  out  REG_BUS_WIDTH  to ifu jump_pc_i
trap_busy_o  out  1  trap sequence in progress
halted_o  out  1  core in HALT
stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge): state=RUN, trap_pc_r=0, wdog=0, stall_timeout_o=0. Combinational outputs then evaluate to stall_o=0, flush_o=0, redirect_req_o=0, redirect_pc_o=0, trap_busy_o=0, halted_o=0. Reset mid-trap or mid-halt abandons the sequence with no redirect.
- States: RUN, DRAIN, REDIR, HALT. All outputs are combinational from state plus inputs; no extra latency.
- RUN stall mapping, priority mem > ex > id:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - none: 0
- RUN jump arbitration: redirect_req_o=jump_req_i only when no stall request is active and trap_req_i=0, with redirect_pc_o=jump_pc_i. Otherwise the jump is suppressed and idu re-asserts it.
- RUN transitions:
  - trap_req_i=1: latch trap_vec_i into trap_pc_r. Go to DRAIN if stallreq_mem_i=1, else REDIR. Trap wins over a same-cycle jump and halt.
  - Else halt_req_i=1: go to HALT.
- DRAIN: stall_o=6'b011111, trap_busy_o=1. Exit to REDIR on the first cycle with stallreq_mem_i=0.
- REDIR (exactly 1 cycle): redirect_req_o=1, redirect_pc_o=trap_pc_r, flush_o=6'b011110, stall_o=0, trap_busy_o=1. Next state RUN.
- Ignored during DRAIN/REDIR: trap_req_i, jump_req_i, halt_req_i.
- HALT: stall_o=6'b111111, halted_o=1. Return to RUN when halt_req_i=0.
- trap_req_i in HALT: latched, takes DRAIN/REDIR path on exit (trap before resume).
- Watchdog:
  - Increments each cycle stall_o!=0 in RUN or DRAIN; saturates at WDOG_CYCLES.
  - Clears on any cycle with stall_o==0, and holds in HALT.
  - stall_timeout_o sets when count reaches WDOG_CYCLES; cleared only by reset.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cyc_o[31:0] and perf_flush_cnt_o[31:0], both reset 0.
  - perf_stall_cyc_o increments on every cycle with stall_o[0]=1, including HALT.
  - perf_flush_cnt_o increments on every REDIR cycle and every forwarded jump.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- defines.v holds:
  - STALL_NONE/STALL_ID/STALL_EX/STALL_MEM/STALL_ALL stall encodings
  - FLUSH_TRAP=6'b011110
  - state encodings PCTRL_RUN/DRAIN/REDIR/HALT
  - REG_BUS/REG_BUS_WIDTH (existing)
- One sub-module, stall_wdog: saturating counter plus sticky flag, parameterised by WDOG_CYCLES/WDOG_W. Inputs clk, rst_n, inc, clr, hold; output timeout.

Test Plan:
- Stall priority:
  - stallreq_id_i=1 -> stall_o=6'b000111.
  - Add stallreq_mem_i=1 -> 6'b011111.
  - Only ex -> 6'b001111.
  - Jump during any stall -> redirect_req_o=0.
- Clean jump: jump_req_i=1, jump_pc_i=32'h80 with no stalls -> same-cycle redirect_req_o=1, redirect_pc_o=32'h80, flush_o=0.
- Trap with mem wait:
  - Inputs: trap_req_i=1, trap_vec_i=32'h100, stallreq_mem_i=1 for 3 cycles.
  - -> DRAIN 3 cycles with stall_o=6'b011111.
  - -> then one cycle redirect_pc_o=32'h100, flush_o=6'b011110.
  - -> then RUN; trap_busy_o=1 throughout.
- Trap vs jump same cycle: trap_vec_i=32'h200, jump_pc_i=32'h40, no stalls -> next cycle redirect_pc_o=32'h200; the jump is never forwarded.
- Halt:
  - halt_req_i=1 for 5 cycles -> halted_o=1, stall_o=6'b111111.
  - Trap asserted during halt -> after release, REDIR to trap vector.
- Watchdog (WDOG_CYCLES=4):
  - stallreq_ex_i held 4 cycles -> stall_timeout_o=1, stays set after the stall drops.
  - rst_n=0 in DRAIN -> next cycle state RUN, all outputs 0.
